// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM request arbiter.
//   t_arb_state : arbiter FSM state
//   t_arb_cmd   : latched command (address + direction)
//   c_streak_w  : width of the read-streak counter (supports limits up to 15)
//   c_req_addrw : request address width carried by t_arb_cmd
package sdram_arb_pkg;

  localparam int unsigned c_streak_w  = 4;
  localparam int unsigned c_req_addrw = 24;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_WR,
    ISSUE_RD
  } t_arb_state;

  typedef struct packed {
    logic [c_req_addrw-1:0] addr;
    logic                   is_write;
  } t_arb_cmd;

endpackage

// File: rtl/sdram_req_arbiter_credit_counter.sv
// Up/down credit counter with saturation at p_max and a sticky overflow flag.
//   i_clk, i_rst : clock, asynchronous active-high reset (count resets to p_max)
//   i_take       : consume one credit
//   i_give       : return one credit
//   o_count      : credits available
//   o_err        : sticky, set when a credit is returned while already full
module credit_counter #(
  parameter int unsigned p_max   = 64,
  parameter int unsigned p_width = 7
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_take,
  input  logic               i_give,
  output logic [p_width-1:0] o_count,
  output logic               o_err
);

  localparam logic [p_width-1:0] c_max = p_width'(p_max);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_count <= c_max;
      o_err   <= 1'b0;
    end else begin
      unique case ({i_take, i_give})
        2'b10: begin
          if (o_count != '0) o_count <= o_count - 1'b1;
        end
        2'b01: begin
          if (o_count == c_max) o_err   <= 1'b1;
          else                  o_count <= o_count + 1'b1;
        end
        default: ;  // idle, or take and give cancel out
      endcase
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Single-port scheduler in front of sdram_ctrl. Grants one burst command at a
// time; reads win for display deadlines, but after p_max_rd_streak consecutive
// read grants a pending write goes first. Reads are gated by credits tracking
// free space in the downstream read-data FIFO.
//   i_clk, i_rst            : DRAM clock, asynchronous active-high reset
//   i_ctrl_init             : controller ready for commands
//   i_wr_valid/addr/data    : write burst request; o_wr_ready accepts it
//   i_rd_valid/addr         : read burst request;  o_rd_ready accepts it
//   o_ctrl_wr_*             : held write command;  i_ctrl_wr_ready completes it
//   o_ctrl_rd_*             : held read command;   i_ctrl_rd_ready completes it
//   i_rd_burst_done         : credit return, one pulse per drained burst
//   o_rd_credits            : credits currently available
//   o_credit_err            : sticky credit overflow
//   o_busy                  : a command is being held for the controller
module sdram_req_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned p_burst_size    = 8,
  parameter int unsigned p_dram_dataw    = 16,
  parameter int unsigned p_req_addrw     = 24,
  parameter int unsigned p_max_rd_streak = 4,
  parameter int unsigned p_rd_credits    = 64
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_ctrl_init,
  input  logic                             i_wr_valid,
  input  logic [p_req_addrw-1:0]           i_wr_addr,
  input  logic [p_dram_dataw-1:0]          i_wr_data [p_burst_size],
  output logic                             o_wr_ready,
  input  logic                             i_rd_valid,
  input  logic [p_req_addrw-1:0]           i_rd_addr,
  output logic                             o_rd_ready,
  output logic                             o_ctrl_wr_req,
  output logic [p_req_addrw-1:0]           o_ctrl_wr_addr,
  output logic [p_dram_dataw-1:0]          o_ctrl_wr_data [p_burst_size],
  input  logic                             i_ctrl_wr_ready,
  output logic                             o_ctrl_rd_req,
  output logic [p_req_addrw-1:0]           o_ctrl_rd_addr,
  input  logic                             i_ctrl_rd_ready,
  input  logic                             i_rd_burst_done,
  output logic [$clog2(p_rd_credits+1)-1:0] o_rd_credits,
  output logic                             o_credit_err,
  output logic                             o_busy
);

  localparam int unsigned           c_cred_w     = $clog2(p_rd_credits + 1);
  localparam logic [c_streak_w-1:0] c_streak_max = c_streak_w'(p_max_rd_streak);

  t_arb_state              state;
  t_arb_cmd                cmd;
  logic [c_streak_w-1:0]   streak;
  logic [p_dram_dataw-1:0] wr_data_q [p_burst_size];
  logic [c_cred_w-1:0]     credits;
  logic                    rd_elig;
  logic                    wr_elig;
  logic                    rd_grant;
  logic                    wr_grant;
  logic                    issue_done;

  always_comb begin
    rd_elig  = 1'b0;
    wr_elig  = 1'b0;
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (state == IDLE && i_ctrl_init) begin
      rd_elig  = i_rd_valid && (credits != '0);
      wr_elig  = i_wr_valid;
      rd_grant = rd_elig && (!wr_elig || (streak < c_streak_max));
      wr_grant = wr_elig && !rd_grant;
    end
  end

  // Completion is selected by the latched direction, so both ISSUE states
  // share a single exit condition.
  always_comb begin
    issue_done = cmd.is_write ? i_ctrl_wr_ready : i_ctrl_rd_ready;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      cmd           <= '0;
      streak        <= '0;
      o_ctrl_wr_req <= 1'b0;
      o_ctrl_rd_req <= 1'b0;
      for (int unsigned i = 0; i < p_burst_size; i++) wr_data_q[i] <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (rd_grant) begin
            state         <= ISSUE_RD;
            cmd.addr      <= i_rd_addr;
            cmd.is_write  <= 1'b0;
            o_ctrl_rd_req <= 1'b1;
            if (streak != c_streak_max) streak <= streak + 1'b1;
          end else if (wr_grant) begin
            state         <= ISSUE_WR;
            cmd.addr      <= i_wr_addr;
            cmd.is_write  <= 1'b1;
            o_ctrl_wr_req <= 1'b1;
            streak        <= '0;
            for (int unsigned i = 0; i < p_burst_size; i++) wr_data_q[i] <= i_wr_data[i];
          end
        end
        ISSUE_WR, ISSUE_RD: begin
          if (issue_done) begin
            state         <= IDLE;
            o_ctrl_wr_req <= 1'b0;
            o_ctrl_rd_req <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  credit_counter #(
    .p_max   (p_rd_credits),
    .p_width (c_cred_w)
  ) u_credit_counter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_take  (rd_grant),
    .i_give  (i_rd_burst_done),
    .o_count (credits),
    .o_err   (o_credit_err)
  );

  assign o_wr_ready     = wr_grant;
  assign o_rd_ready     = rd_grant;
  assign o_ctrl_wr_addr = cmd.addr;
  assign o_ctrl_rd_addr = cmd.addr;
  assign o_ctrl_wr_data = wr_data_q;
  assign o_rd_credits   = credits;
  assign o_busy         = (state != IDLE);

endmodule

// File: doc/sdram_req_arbiter.md
# sdram_req_arbiter

Single-port scheduler between the SDRAM write path (camera burst write requests) and the read path (display line-prefetch read requests) and the one `sdram_ctrl` instance. Grants one burst command at a time; reads have priority for display deadlines, with a write anti-starvation streak limit. Read issue is gated by a credit counter that tracks free space in the downstream read-data FIFO. Sits in the DRAM clock domain, after the write width adapter and the read request FIFO, and drives `sdram_ctrl` request ports directly.

## Interface
- `p_burst_size`, 8: words per burst command.
- `p_dram_dataw`, 16: SDRAM word width.
- `p_req_addrw`, 24: request address width (bank+col+row), passed through unmodified.
- `p_max_rd_streak`, 4: consecutive read grants allowed while a write is pending; range 1..15.
- `p_rd_credits`, 64: read-data FIFO capacity in bursts; range 1..255.
- `i_clk`, in, 1: DRAM clock; all logic on its rising edge.
- `i_rst`, in, 1: reset; asynchronous, active-high.
- `i_ctrl_init`, in, 1: controller initialised (`o_ready` of `sdram_ctrl`); no grants while low.
- `i_wr_valid`, in, 1: write burst request.
- `i_wr_addr`, in, p_req_addrw: write burst address.
- `i_wr_data`, in, p_dram_dataw × p_burst_size: unpacked burst data array.
- `o_wr_ready`, out, 1: write request accepted this cycle.
- `i_rd_valid`, in, 1: read burst request.
- `i_rd_addr`, in, p_req_addrw: read burst address.
- `o_rd_ready`, out, 1: read request accepted this cycle.
- `o_ctrl_wr_req`, `o_ctrl_wr_addr`, `o_ctrl_wr_data`, out: write command to controller.
- `i_ctrl_wr_ready`, in, 1: controller took the write command.
- `o_ctrl_rd_req`, `o_ctrl_rd_addr`, out: read command to controller.
- `i_ctrl_rd_ready`, in, 1: controller took the read command.
- `i_rd_burst_done`, in, 1: one-cycle pulse per burst drained from the read-data FIFO (credit return).
- `o_rd_credits`, out, $clog2(p_rd_credits+1): credits currently available.
- `o_credit_err`, out, 1: sticky; set on credit return while counter is full.
- `o_busy`, out, 1: a command is held for the controller (state ≠ IDLE).

## Operation
- FSM states: IDLE, ISSUE_WR, ISSUE_RD.
- IDLE: if `i_ctrl_init`=0, no grant. A read is eligible when `i_rd_valid` is high and credits > 0. A write is eligible when `i_wr_valid` is high.
  - If a read is eligible and (no write is eligible, or streak < p_max_rd_streak): assert `o_rd_ready`, latch the address, and decrement credits. Increment streak, saturating at p_max_rd_streak. Go to ISSUE_RD.
  - Otherwise, if a write is eligible: assert `o_wr_ready`, latch the address and data, clear streak. Go to ISSUE_WR.
  - At most one of `o_wr_ready`/`o_rd_ready` is high in any cycle. Both are low outside IDLE.
- ISSUE_WR: `o_ctrl_wr_req`=1 with the latched addr/data held stable. On `i_ctrl_wr_ready`=1 the command completes and the FSM returns to IDLE; `o_ctrl_wr_req` is low the next cycle.
- ISSUE_RD: same as ISSUE_WR, using `o_ctrl_rd_req` and `i_ctrl_rd_ready`.
- Credit counter:
  - Grant only: −1. Return only: +1. Both in the same cycle: unchanged.
  - A return at p_rd_credits keeps the counter at p_rd_credits and sets `o_credit_err`.
  - The counter never goes below 0, because a read is never granted at 0.
- `i_ctrl_init` falling mid-ISSUE does not abort the held command.

## Timing
- Reset values: state IDLE; all ready and req outputs 0; ctrl addr/data 0; streak 0; `o_rd_credits`=p_rd_credits; `o_credit_err`=0; `o_busy`=0.
- Reset asserted mid-operation clears everything asynchronously and drops the held command. Upstream must re-request.
- `o_wr_ready`/`o_rd_ready` are combinational from IDLE state, valids, credits and streak. The upstream handshake is valid & ready in the same cycle.
- Accept in cycle N → ctrl req high in cycle N+1. If ctrl ready is high in N+1, the next accept is possible in N+2. Peak rate is one burst per 2 cycles.
- `o_rd_credits` reflects a grant or return the cycle after it occurs.

## Structure
- Package `sdram_arb_pkg`:
  - `t_arb_state` enum (IDLE, ISSUE_WR, ISSUE_RD).
  - `t_arb_cmd` packed struct (addr, is_write).
  - Constant `c_streak_w` = 4.
- One sub-module, `credit_counter`: up/down counter with saturation and sticky error. Parameters: max and width. Ports: i_clk, i_rst, i_take, i_give, o_count, o_err.

## Test plan
- After reset with `i_ctrl_init`=1, only `i_wr_valid` pulses once (addr 0x000100) → `o_wr_ready` in cycle N; `o_ctrl_wr_req`=1 with addr 0x000100 in N+1. With ctrl ready held, IDLE in N+2.
- Both valids held continuously, p_max_rd_streak=4, ctrl ready always 1 → grant order R,R,R,R,W,R,R,R,R,W…; never two accepts in consecutive cycles.
- p_rd_credits=2, reads only, no `i_rd_burst_done` → exactly 2 read grants, then `o_rd_ready` stays 0 and `o_rd_credits`=0. One done pulse → exactly one more grant.
- `i_ctrl_rd_ready` held low for 10 cycles in ISSUE_RD → `o_ctrl_rd_req` and addr stable for all 10 cycles; no upstream ready asserted.
- Grant and `i_rd_burst_done` in the same cycle → credits unchanged. Done pulse while credits=p_rd_credits → counter unchanged, `o_credit_err`=1 until reset.
- `i_rst` asserted in ISSUE_WR → `o_ctrl_wr_req`=0 immediately (asynchronous); after release, state IDLE and credits=p_rd_credits.
